// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared types and default sizes for the word-to-serial pattern detector.
//   state_t      : controller FSM states (IDLE, WAIT, SHIFT)
//   DEF_W        : default input word width
//   DEF_PAT_LEN  : default pattern length in bits
//   DEF_CW       : default match counter width
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int DEF_W       = 8;
    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_CW      = 8;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if
//   Word handshake between a producer and seq_detect_ctrl.
//   in_valid : producer has a word
//   in_data  : the word (W bits)
//   in_ready : controller takes the word this cycle
//   master   : producer side; slave : controller side
interface seq_detect_ctrl_if #(parameter int W = 8);

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/seq_match_core.sv
// seq_match_core
//   Bit-serial matcher: keeps a PAT_LEN-bit history and a fill counter, compares
//   the latest PAT_LEN bits (oldest = MSB) against pattern, registers a match pulse.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     clear        : synchronous clear of history, fill and match
//     bit_in       : serial bit
//     bit_valid    : bit_in is meaningful this cycle
//     pattern      : pattern to detect
//     hit          : combinational, the current bit completes a match
//     match        : hit registered (one-cycle pulse the cycle after the bit)
//   Build option: SEQDET_OVERLAP_EN keeps history/fill after a match so that
//   overlapping occurrences count; without it a match restarts the fill.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               hit,
    output logic               match
);

    localparam int FW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN:0]   win;

    // Window = history with the current bit appended; the low PAT_LEN bits are
    // the candidate sequence. Needs PAT_LEN-1 earlier bits plus the current one.
    assign win = {hist, bit_in};
    assign hit = bit_valid && (fill >= FW'(PAT_LEN - 1)) &&
                 (win[PAT_LEN-1:0] == pattern);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (bit_valid) begin
                hist <= win[PAT_LEN-1:0];
`ifdef SEQDET_OVERLAP_EN
                if (fill != FW'(PAT_LEN))
                    fill <= fill + FW'(1);
`else
                // A match consumes its bits: PAT_LEN fresh bits are needed again.
                if (hit)
                    fill <= '0;
                else if (fill != FW'(PAT_LEN))
                    fill <= fill + FW'(1);
`endif
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Takes W-bit words over a valid/ready handshake, shifts them out MSB-first one
//   bit per clk, counts pattern matches (saturating) and raises a sticky irq when
//   the count reaches a threshold.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     start               : in IDLE, latch config, clear history/count/irq, go WAIT
//     stop                : return to IDLE once the word in flight is finished
//     cfg_pattern         : pattern (MSB oldest), sampled at start
//     cfg_thresh          : irq threshold, sampled at start, 0 disables irq
//     in_if (slave)       : in_valid / in_data / in_ready word handshake
//     bit_out, bit_valid  : serial output
//     match               : one-cycle pulse per detected pattern
//     match_count         : saturating match count
//     irq, irq_clr        : sticky interrupt and its clear (set wins)
//     busy                : controller is not IDLE
//   Build option: SEQDET_OVERLAP_EN (overlapping matches, see seq_match_core).
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CW      = DEF_CW
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [CW-1:0]      cfg_thresh,
    seq_detect_ctrl_if.slave   in_if,
    output logic               bit_out,
    output logic               bit_valid,
    output logic               match,
    output logic [CW-1:0]      match_count,
    output logic               irq,
    input  logic               irq_clr,
    output logic               busy
);

    localparam int IW = $clog2(W);

    state_t             state;
    logic               in_ready_q;
    // The MSB goes straight to bit_out on accept, so only the rest is stored.
    logic [W-2:0]       rest;
    logic [IW-1:0]      idx;
    logic               stop_pend;
    logic [PAT_LEN-1:0] pat_q;
    logic [CW-1:0]      thr_q;

    logic               clear;
    logic               hit;
    logic               cnt_max;
    logic [CW-1:0]      cnt_inc;
    logic               irq_set;

    assign in_if.in_ready = in_ready_q;

    assign clear   = (state == IDLE) && start;
    assign cnt_max = &match_count;
    assign cnt_inc = match_count + CW'(1);
    // Only an actual increment onto the threshold sets irq; a saturated count
    // sitting at the threshold does not re-arm it.
    assign irq_set = hit && !cnt_max && (cnt_inc == thr_q) && (thr_q != '0);

    seq_match_core #(.PAT_LEN(PAT_LEN)) u_core (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .bit_in    (bit_out),
        .bit_valid (bit_valid),
        .pattern   (pat_q),
        .hit       (hit),
        .match     (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            rest        <= '0;
            idx         <= '0;
            stop_pend   <= 1'b0;
            pat_q       <= '0;
            thr_q       <= '0;
            match_count <= '0;
            irq         <= 1'b0;
        end else begin
            if (hit && !cnt_max)
                match_count <= cnt_inc;

            if (irq_set)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= WAIT;
                        in_ready_q  <= 1'b1;
                        busy        <= 1'b1;
                        pat_q       <= cfg_pattern;
                        thr_q       <= cfg_thresh;
                        match_count <= '0;
                        irq         <= 1'b0;
                        stop_pend   <= 1'b0;
                        idx         <= '0;
                    end
                end
                WAIT: begin
                    if (in_if.in_valid) begin
                        // A stop arriving with the word is deferred until it is shifted out.
                        rest       <= in_if.in_data[W-2:0];
                        bit_out    <= in_if.in_data[W-1];
                        bit_valid  <= 1'b1;
                        idx        <= IW'(W - 1);
                        in_ready_q <= 1'b0;
                        stop_pend  <= stop;
                        state      <= SHIFT;
                    end else if (stop) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (idx == '0) begin
                        bit_valid <= 1'b0;
                        bit_out   <= 1'b0;
                        if (stop_pend || stop) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state      <= WAIT;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        idx     <= idx - IW'(1);
                        bit_out <= rest[idx - IW'(1)];
                        if (stop)
                            stop_pend <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                    bit_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
//   Directed bench. Instance a: W=8, PAT_LEN=4, CW=8 (serialisation, latency,
//   cross-word match, irq, stop, reset). Instance b: W=8, PAT_LEN=3, CW=2
//   (overlap behaviour under SEQDET_OVERLAP_EN, count saturation).
module tb_seq_detect_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // instance a
    logic       a_rst, a_start, a_stop, a_irq_clr;
    logic [3:0] a_pat;
    logic [7:0] a_thr;
    logic       a_bit, a_bv, a_match, a_irq, a_busy;
    logic [7:0] a_cnt;
    seq_detect_ctrl_if #(.W(8)) a_if();

    seq_detect_ctrl #(.W(8), .PAT_LEN(4), .CW(8)) dut_a (
        .clk(clk), .reset(a_rst), .start(a_start), .stop(a_stop),
        .cfg_pattern(a_pat), .cfg_thresh(a_thr), .in_if(a_if),
        .bit_out(a_bit), .bit_valid(a_bv), .match(a_match),
        .match_count(a_cnt), .irq(a_irq), .irq_clr(a_irq_clr), .busy(a_busy)
    );

    // instance b
    logic       b_rst, b_start, b_stop, b_irq_clr;
    logic [2:0] b_pat;
    logic [1:0] b_thr;
    logic       b_bit, b_bv, b_match, b_irq, b_busy;
    logic [1:0] b_cnt;
    seq_detect_ctrl_if #(.W(8)) b_if();

    seq_detect_ctrl #(.W(8), .PAT_LEN(3), .CW(2)) dut_b (
        .clk(clk), .reset(b_rst), .start(b_start), .stop(b_stop),
        .cfg_pattern(b_pat), .cfg_thresh(b_thr), .in_if(b_if),
        .bit_out(b_bit), .bit_valid(b_bv), .match(b_match),
        .match_count(b_cnt), .irq(b_irq), .irq_clr(b_irq_clr), .busy(b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sends one word to a (must be in WAIT) and checks the 8 bits plus the match
    // line over cycles N+1..N+9. mexp[k] = expected match at sample k.
    // clr_k / stop_k: sample at which irq_clr / stop is driven for one cycle;
    // stop_k < 0 drives stop together with in_valid.
    task automatic a_word(input logic [7:0] w, input logic [8:0] mexp,
                          input int clr_k, input int stop_k);
        chk("a_ready_pre", a_if.in_ready, 1);
        a_if.in_valid = 1'b1;
        a_if.in_data  = w;
        a_stop        = (stop_k < 0);
        tick;
        a_if.in_valid = 1'b0;
        a_stop        = 1'b0;
        for (int k = 0; k < 9; k++) begin
            a_irq_clr = (k == clr_k);
            a_stop    = (k == stop_k);
            if (k < 8) begin
                chk($sformatf("a_bv[%0d]", k), a_bv, 1);
                chk($sformatf("a_bit[%0d]", k), a_bit, w[7-k]);
                chk($sformatf("a_ready_shift[%0d]", k), a_if.in_ready, 0);
            end else begin
                chk("a_bv_end", a_bv, 0);
            end
            chk($sformatf("a_match[%0d]", k), a_match, mexp[k]);
            if (k < 8) tick;
        end
        a_irq_clr = 1'b0;
        a_stop    = 1'b0;
    endtask

    // Sends one word to b and ends in cycle N+9 (count final for this word).
    task automatic b_word(input logic [7:0] w);
        chk("b_ready_pre", b_if.in_ready, 1);
        b_if.in_valid = 1'b1;
        b_if.in_data  = w;
        tick;
        b_if.in_valid = 1'b0;
        repeat (8) tick;
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_irq_clr = 1'b0;
        a_pat = '0; a_thr = '0; a_if.in_valid = 1'b0; a_if.in_data = '0;
        b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_irq_clr = 1'b0;
        b_pat = '0; b_thr = '0; b_if.in_valid = 1'b0; b_if.in_data = '0;
        tick; tick;
        a_rst = 1'b0; b_rst = 1'b0;

        // reset state
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_if.in_ready, 0);
        chk("rst_bv", a_bv, 0);
        chk("rst_bit", a_bit, 0);
        chk("rst_match", a_match, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_irq", a_irq, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_cnt", b_cnt, 0);

        // single word, pattern 1011 -> match at the sample after the 4th bit
        a_pat = 4'b1011; a_thr = 8'd0; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        chk("t2_busy", a_busy, 1);
        a_word(8'b1011_0000, 9'b0_0001_0000, 99, 99);
        chk("t2_cnt", a_cnt, 1);

        // start in WAIT is ignored (pattern 0000 would match the zeros below)
        a_pat = 4'b0000; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        chk("ign_start_cnt", a_cnt, 1);

        // pattern spanning two words: only the first bit of word 2 completes it
        a_word(8'b0000_0101, 9'b0, 99, 99);
        chk("t3_cnt_w1", a_cnt, 1);
        a_word(8'b1000_0000, 9'b0_0000_0010, 99, 99);
        chk("t3_cnt_w2", a_cnt, 2);

        // stop together with valid: word is taken and shifted, then IDLE
        a_word(8'b0000_0000, 9'b0, 99, -1);
        chk("stopv_busy", a_busy, 0);
        chk("stopv_ready", a_if.in_ready, 0);
        chk("stopv_cnt", a_cnt, 2);

        // irq at threshold 2; set wins over clr; clr with a non-threshold match
        a_pat = 4'b1011; a_thr = 8'd2; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        chk("t5_cnt_clr", a_cnt, 0);
        a_word(8'b1011_0000, 9'b0_0001_0000, 99, 99);
        chk("t5_cnt1", a_cnt, 1);
        chk("t5_irq1", a_irq, 0);
        a_word(8'b1011_0000, 9'b0_0001_0000, 3, 99);
        chk("t5_cnt2", a_cnt, 2);
        chk("t5_irq2", a_irq, 1);
        a_word(8'b1011_0000, 9'b0_0001_0000, 3, 99);
        chk("t5_cnt3", a_cnt, 3);
        chk("t5_irq3", a_irq, 0);

        // reset in the middle of SHIFT
        chk("t1_ready", a_if.in_ready, 1);
        a_if.in_valid = 1'b1; a_if.in_data = 8'b1011_0000;
        tick;
        a_if.in_valid = 1'b0;
        tick; tick;
        a_rst = 1'b1;
        tick;
        a_rst = 1'b0;
        chk("t1_busy", a_busy, 0);
        chk("t1_bv", a_bv, 0);
        chk("t1_cnt", a_cnt, 0);
        chk("t1_ready", a_if.in_ready, 0);
        chk("t1_match", a_match, 0);
        tick; tick; tick;
        chk("t1_match_late", a_match, 0);
        chk("t1_cnt_late", a_cnt, 0);

        // stop during SHIFT: remaining bits still go out, then IDLE for good
        a_thr = 8'd0; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        a_word(8'b1011_0000, 9'b0_0001_0000, 99, 2);
        chk("t6_busy", a_busy, 0);
        chk("t6_ready", a_if.in_ready, 0);
        chk("t6_cnt", a_cnt, 1);
        a_if.in_valid = 1'b1; a_if.in_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("t6_ready_idle[%0d]", i), a_if.in_ready, 0);
            chk($sformatf("t6_bv_idle[%0d]", i), a_bv, 0);
        end
        a_if.in_valid = 1'b0;

        // overlap behaviour, pattern 101, stream 10101000
        b_pat = 3'b101; b_thr = 2'd0; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        b_word(8'b1010_1000);
`ifdef SEQDET_OVERLAP_EN
        chk("t4_cnt", b_cnt, 2);
`else
        chk("t4_cnt", b_cnt, 1);
`endif

        // saturation at 3 with CW=2: matches per word 2,1,1,1 in either mode
        b_stop = 1'b1;
        tick;
        b_stop = 1'b0;
        chk("b_idle", b_busy, 0);
        b_thr = 2'd3; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        chk("b_cnt_clr", b_cnt, 0);
        b_word(8'b1010_0101);
        chk("sat_cnt1", b_cnt, 2);
        chk("sat_irq1", b_irq, 0);
        b_word(8'b0010_1000);
        chk("sat_cnt2", b_cnt, 3);
        chk("sat_irq2", b_irq, 1);
        b_word(8'b0010_1000);
        chk("sat_cnt3", b_cnt, 3);
        b_word(8'b0010_1000);
        chk("sat_cnt4", b_cnt, 3);
        chk("sat_irq4", b_irq, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
